led_pwm_fader: RTL and testbench
================================

Name: led_pwm_fader

Overview:
Downstream consumer of the 8-bit counter pattern produced by the counter stage in the 60 MHz domain. Latches an 8-bit LED pattern and drives eight LED pins with per-LED PWM. Each LED's duty cycle ramps toward on (255) or off (0) by a fixed step once per PWM period, so pattern changes fade rather than snap. Sits between the counter stage and the top-level LED pins.

Parameters:
PRESCALE, 235, clk cycles per PWM phase tick. Legal range is 1..65535. The default gives about 997 Hz PWM at 60 MHz.
FADE_STEP, 8, duty increment/decrement per PWM period. Legal range is 1..255.

Ports:
clk  input  1  system clock (60 MHz domain)
rst  input  1  synchronous reset, active-low; sampled on rising edge of clk
value_in  input  8  requested LED pattern; bit i controls led_out[i]
value_valid  input  1  single-cycle strobe; latch value_in this cycle
led_out  output  8  PWM LED drive, registered
settled  output  1  high when every duty register has reached its target extreme
target_out  output  8  currently latched target pattern, registered

Behaviour:
- Reset (rst==0 at a clk edge) sets the following, overriding everything else including value_valid:
  - prescaler = 0, phase = 0, all duty[i] = 0, target = 0.
  - led_out = 0, target_out = 0, settled = 1.
  - Reset asserted mid-fade or mid-period discards all state.
- Prescaler:
  - 16-bit counter, 0..PRESCALE-1.
  - tick = (prescaler == PRESCALE-1); on tick it wraps to 0.
  - With PRESCALE==1, tick is high every cycle.
- Phase:
  - 8-bit counter; increments on tick, wraps 255->0.
  - period_end = tick && phase==255.
- Target latch:
  - On value_valid, target <= value_in at that edge.
  - target_out mirrors the target register.
  - Back-to-back strobes: the last one wins.
- Fade, applied on period_end only, for each i:
  - if target[i]==1: duty[i] <= min(duty[i]+FADE_STEP, 255).
  - else: duty[i] <= max(duty[i]-FADE_STEP, 0).
  - Use 9-bit intermediate arithmetic; saturate, never wrap.
  - If value_valid and period_end fall on the same edge, the fade uses the OLD target and the new target takes effect at the next period_end.
- PWM output, registered, one cycle after phase/duty are sampled:
  - led_out[i] <= 1 if duty[i]==255, else (phase < duty[i]).
  - duty 0 gives constant 0; duty 255 gives constant 1 with no glitch at phase 255.
- settled, registered:
  - 1 when for all i, duty[i] == (target[i] ? 255 : 0), else 0.
  - Evaluated on register values, so it reflects a new target one cycle after the latch edge.
- Fade duration: ceil(255/FADE_STEP) periods from one extreme to the other. With the default step, 32 periods (about 32 ms).
- Duty is never loaded directly from value_in; fades start from the current duty (reversal mid-fade is smooth).

Test Plan:
1. Reset check: hold rst=0 for 4 cycles with value_valid=1, value_in=8'hFF. Required: led_out=0, target_out=0, settled=1 throughout, and 1 cycle after release.
2. Fade-in with PRESCALE=1, FADE_STEP=64: strobe 8'h01, then count periods.
   - target_out=8'h01 one cycle after the strobe; settled drops to 0 one cycle later.
   - duty[0] steps 64, 128, 192, 255 at successive period_ends.
   - led_out[0] high for exactly 64, 128, 192 of 256 cycles in periods 2, 3, 4, then constantly 1 in period 5; settled=1 after the 4th period_end.
   - led_out[7:1] stays 0.
3. Saturation with FADE_STEP=255: strobe 8'hAA. Required:
   - After 1 period_end, odd bits are constant 1 and even bits constant 0; settled=1.
   - Strobe 8'h55: all outputs swap after exactly 1 period_end, with no duty wrap (no 0->255 flicker).
4. Mid-fade reversal with FADE_STEP=64: strobe 8'h01, wait 2 period_ends (duty=128), then strobe 8'h00. Required: duty steps 64, then 0; led_out[0] high for 64 cycles, then constantly 0.
5. Simultaneous event: assert value_valid=1 with 8'hFF exactly on the period_end edge while target=0 and duty=0. Required:
   - All duties stay 0 at that edge; target_out=8'hFF next cycle.
   - Duties reach FADE_STEP at the following period_end.
6. Reset mid-fade: during test 2 at duty=128, assert rst=0 for 1 cycle. Required: led_out=0 and target_out=0 next cycle; no further fading without a new strobe; settled=1.

Source files
------------

// File: rtl/led_pwm_fader.sv
// Latches an 8-bit LED pattern and drives eight PWM outputs. Each duty ramps
// toward full-on or full-off once per PWM period, so pattern changes fade.
module led_pwm_fader #(
  parameter int unsigned PRESCALE  = 235,
  parameter int unsigned FADE_STEP = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] value_in,
  input  logic       value_valid,
  output logic [7:0] led_out,
  output logic       settled,
  output logic [7:0] target_out
);

  localparam logic [15:0] PRESCALE_MAX = 16'(PRESCALE - 1);
  localparam logic [8:0]  STEP         = 9'(FADE_STEP);

  logic [15:0] prescale_q, prescale_d;
  logic [7:0]  phase_q, phase_d;
  logic [7:0]  duty_q [8];
  logic [7:0]  duty_d [8];
  logic [8:0]  duty_up [8];
  logic [8:0]  duty_dn [8];
  logic [7:0]  target_q, target_d;
  logic [7:0]  led_q, led_d;
  logic        settled_q, settled_d;
  logic        tick;
  logic        period_end;

  always_comb begin
    tick       = (prescale_q == PRESCALE_MAX);
    period_end = tick && (phase_q == 8'hFF);
    prescale_d = tick ? 16'd0 : prescale_q + 16'd1;
    phase_d    = tick ? phase_q + 8'd1 : phase_q;
    // A strobe on the period_end edge only updates target; the fade below
    // still reads target_q, so the new pattern applies from the next period.
    target_d   = value_valid ? value_in : target_q;
    led_d      = '0;
    settled_d  = 1'b1;
    for (int i = 0; i < 8; i++) begin
      duty_up[i] = {1'b0, duty_q[i]} + STEP;
      duty_dn[i] = {1'b0, duty_q[i]} - STEP;
      duty_d[i]  = duty_q[i];
      if (period_end) begin
        if (target_q[i]) begin
          duty_d[i] = (duty_up[i] > 9'd255) ? 8'hFF : duty_up[i][7:0];
        end else begin
          // Bit 8 set means the subtraction borrowed: clamp at zero.
          duty_d[i] = duty_dn[i][8] ? 8'h00 : duty_dn[i][7:0];
        end
      end
      led_d[i] = (duty_q[i] == 8'hFF) || (phase_q < duty_q[i]);
      if (duty_q[i] != (target_q[i] ? 8'hFF : 8'h00)) begin
        settled_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prescale_q <= '0;
      phase_q    <= '0;
      target_q   <= '0;
      led_q      <= '0;
      settled_q  <= 1'b1;
      for (int i = 0; i < 8; i++) begin
        duty_q[i] <= '0;
      end
    end else begin
      prescale_q <= prescale_d;
      phase_q    <= phase_d;
      target_q   <= target_d;
      led_q      <= led_d;
      settled_q  <= settled_d;
      for (int i = 0; i < 8; i++) begin
        duty_q[i] <= duty_d[i];
      end
    end
  end

  assign led_out    = led_q;
  assign settled    = settled_q;
  assign target_out = target_q;

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader: two instances (fast fade, saturating fade) checked
// every cycle against an arithmetic reference model plus directed expectations.
module tb_led_pwm_fader;

  localparam int PS0 = 1;
  localparam int FS0 = 64;
  localparam int PS1 = 2;
  localparam int FS1 = 255;

  logic       clk = 1'b0;
  logic       rst;
  logic       vv;
  logic [7:0] vi;
  logic [7:0] led_a, led_b, tgt_a, tgt_b;
  logic       set_a, set_b;

  int errors = 0;
  int checks = 0;
  int hi_cnt [8];

  int         m_cyc [2];
  int         m_duty [2][8];
  logic [7:0] m_tgt [2];
  logic [7:0] m_led [2];
  logic       m_set [2];

  always #5 clk = ~clk;

  led_pwm_fader #(.PRESCALE(PS0), .FADE_STEP(FS0)) dut_a (
    .clk(clk), .rst(rst), .value_in(vi), .value_valid(vv),
    .led_out(led_a), .settled(set_a), .target_out(tgt_a)
  );

  led_pwm_fader #(.PRESCALE(PS1), .FADE_STEP(FS1)) dut_b (
    .clk(clk), .rst(rst), .value_in(vi), .value_valid(vv),
    .led_out(led_b), .settled(set_b), .target_out(tgt_b)
  );

  function automatic int ps(input int k);
    return (k == 0) ? PS0 : PS1;
  endfunction

  function automatic int fs(input int k);
    return (k == 0) ? FS0 : FS1;
  endfunction

  // Reference: phase and period boundaries derived from a cycle count.
  always @(posedge clk) begin : model
    int len, ph, d;
    bit pe, ok;
    for (int k = 0; k < 2; k++) begin
      len = ps(k) * 256;
      if (!rst) begin
        m_cyc[k] = 0;
        m_tgt[k] = 8'h00;
        m_led[k] = 8'h00;
        m_set[k] = 1'b1;
        for (int i = 0; i < 8; i++) m_duty[k][i] = 0;
      end else begin
        ph = (m_cyc[k] / ps(k)) % 256;
        pe = (m_cyc[k] == len - 1);
        ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
          m_led[k][i] = (m_duty[k][i] == 255) || (ph < m_duty[k][i]);
          if (m_duty[k][i] != (m_tgt[k][i] ? 255 : 0)) ok = 1'b0;
        end
        m_set[k] = ok;
        if (pe) begin
          for (int i = 0; i < 8; i++) begin
            d = m_duty[k][i];
            if (m_tgt[k][i]) m_duty[k][i] = (d + fs(k) > 255) ? 255 : d + fs(k);
            else             m_duty[k][i] = (d - fs(k) < 0) ? 0 : d - fs(k);
          end
        end
        if (vv) m_tgt[k] = vi;
        m_cyc[k] = (m_cyc[k] + 1) % len;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    chk("a_led", 32'(led_a), 32'(m_led[0]));
    chk("a_tgt", 32'(tgt_a), 32'(m_tgt[0]));
    chk("a_set", 32'(set_a), 32'(m_set[0]));
    chk("b_led", 32'(led_b), 32'(m_led[1]));
    chk("b_tgt", 32'(tgt_b), 32'(m_tgt[1]));
    chk("b_set", 32'(set_b), 32'(m_set[1]));
  endtask

  task automatic strobe(input logic [7:0] v);
    vi = v;
    vv = 1'b1;
    tick();
    vv = 1'b0;
  endtask

  // Align to the first cycle of the next full PWM period of instance k and
  // count high cycles per LED over that period.
  task automatic period(input int k);
    int guard;
    int len;
    logic [7:0] l;
    guard = 0;
    len = ps(k) * 256;
    for (int i = 0; i < 8; i++) hi_cnt[i] = 0;
    do begin
      tick();
      guard++;
    end while (m_cyc[k] != 1 && guard < 2000);
    chk("period_sync", 32'(m_cyc[k]), 32'd1);
    for (int n = 0; n < len; n++) begin
      if (n > 0) tick();
      l = (k == 0) ? led_a : led_b;
      for (int i = 0; i < 8; i++) if (l[i]) hi_cnt[i]++;
    end
  endtask

  function automatic int hi_sum(input int lo);
    int s;
    s = 0;
    for (int i = lo; i < 8; i++) s += hi_cnt[i];
    return s;
  endfunction

  initial begin
    int g;
    // Reset overrides a strobe
    rst = 1'b0; vv = 1'b1; vi = 8'hFF;
    repeat (4) begin
      tick();
      chk("rst_led_a", 32'(led_a), 32'd0);
      chk("rst_tgt_a", 32'(tgt_a), 32'd0);
      chk("rst_set_a", 32'(set_a), 32'd1);
      chk("rst_tgt_b", 32'(tgt_b), 32'd0);
    end
    rst = 1'b1; vv = 1'b0; vi = 8'h00;
    tick();
    chk("rel_led_a", 32'(led_a), 32'd0);
    chk("rel_tgt_a", 32'(tgt_a), 32'd0);
    chk("rel_set_a", 32'(set_a), 32'd1);

    // Fade-in of LED0
    strobe(8'h01);
    chk("t2_tgt", 32'(tgt_a), 32'h01);
    chk("t2_set_same", 32'(set_a), 32'd1);
    tick();
    chk("t2_set_drop", 32'(set_a), 32'd0);
    period(0); chk("t2_p64", 32'(hi_cnt[0]), 32'd64);
    chk("t2_others", 32'(hi_sum(1)), 32'd0);
    period(0); chk("t2_p128", 32'(hi_cnt[0]), 32'd128);
    period(0); chk("t2_p192", 32'(hi_cnt[0]), 32'd192);
    period(0); chk("t2_p255", 32'(hi_cnt[0]), 32'd256);
    chk("t2_settled", 32'(set_a), 32'd1);
    chk("t2_others_end", 32'(hi_sum(1)), 32'd0);

    // Fade-out from full on: 255 -> 191 -> 127 -> 63 -> 0
    strobe(8'h00);
    period(0); chk("out_191", 32'(hi_cnt[0]), 32'd191);
    period(0); chk("out_127", 32'(hi_cnt[0]), 32'd127);
    period(0); chk("out_63", 32'(hi_cnt[0]), 32'd63);
    period(0); chk("out_0", 32'(hi_cnt[0]), 32'd0);
    chk("out_settled", 32'(set_a), 32'd1);

    // Mid-fade reversal at duty 128
    strobe(8'h01);
    period(0); chk("t4_up64", 32'(hi_cnt[0]), 32'd64);
    strobe(8'h00);
    period(0); chk("t4_dn64", 32'(hi_cnt[0]), 32'd64);
    period(0); chk("t4_dn0", 32'(hi_cnt[0]), 32'd0);

    // Strobe exactly on the period_end edge
    g = 0;
    while (m_cyc[0] != 255 && g < 600) begin tick(); g++; end
    chk("t5_sync", 32'(m_cyc[0]), 32'd255);
    vi = 8'hFF; vv = 1'b1;
    tick();
    vv = 1'b0;
    chk("t5_tgt", 32'(tgt_a), 32'hFF);
    period(0); chk("t5_hold0", 32'(hi_sum(0)), 32'd0);
    period(0); chk("t5_step0", 32'(hi_cnt[0]), 32'd64);
    chk("t5_step_all", 32'(hi_sum(0)), 32'd512);

    // Reset mid-fade (all duties at 128)
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("t6_led", 32'(led_a), 32'd0);
    chk("t6_tgt", 32'(tgt_a), 32'd0);
    chk("t6_set", 32'(set_a), 32'd1);
    period(0); chk("t6_nofade1", 32'(hi_sum(0)), 32'd0);
    period(0); chk("t6_nofade2", 32'(hi_sum(0)), 32'd0);
    chk("t6_set_end", 32'(set_a), 32'd1);

    // Saturating step on instance B
    strobe(8'hAA);
    period(1);
    for (int i = 0; i < 8; i++) chk("t3_aa", 32'(hi_cnt[i]), (i % 2 == 1) ? 32'd512 : 32'd0);
    chk("t3_aa_set", 32'(set_b), 32'd1);
    strobe(8'h55);
    period(1);
    for (int i = 0; i < 8; i++) chk("t3_55", 32'(hi_cnt[i]), (i % 2 == 0) ? 32'd512 : 32'd0);
    chk("t3_55_set", 32'(set_b), 32'd1);

    // Random strobes and occasional resets against the model
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 15) == 0) begin
        vi = 8'($urandom);
        vv = 1'b1;
      end else begin
        vv = 1'b0;
      end
      rst = ($urandom_range(0, 999) != 0);
      tick();
    end
    vv = 1'b0;
    rst = 1'b1;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

endmodule
